// File: rtl/mem_loader.sv
// mem_loader: boot-time byte loader in front of a processor RAM.
// A byte stream fills the reset vector (lo, hi) and then RAM from LOAD_BASE
// upward; the processor is held in reset until the stream ends plus a short
// release window. Reads are served in every state with one cycle of latency.
// Optional feature: define MEM_WRITE_EN to add the processor write port
// (we, wr_data), which writes RAM while the processor runs.
module mem_loader #(
    parameter int unsigned RAM_AW         = 12,
    parameter logic [15:0] LOAD_BASE      = 16'h0000,
    parameter int unsigned RELEASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] address,
    output logic [7:0]  rd_data,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        proc_resetn,
    output logic        load_ovf
`ifdef MEM_WRITE_EN
    ,
    input  logic        we,
    input  logic [7:0]  wr_data
`endif
);

    localparam int unsigned RamDepth = 1 << RAM_AW;
    localparam int unsigned BaseInt  = 32'(LOAD_BASE);
    // A base at or beyond the RAM top starts the pointer already saturated.
    localparam int unsigned BaseSat  = (BaseInt >= RamDepth) ? RamDepth : BaseInt;
    localparam logic [RAM_AW:0] PtrBase = BaseSat[RAM_AW:0];

    localparam int unsigned CntW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CntW-1:0] RelLast = (RELEASE_CYCLES > 0) ? CntW'(RELEASE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        StVecLo,
        StVecHi,
        StLoad,
        StRelease,
        StRun
    } state_e;

    state_e            state_q;
    logic [7:0]        vec_lo_q;
    logic [7:0]        vec_hi_q;
    // One extra bit so the pointer can sit at exactly 2^RAM_AW (full).
    logic [RAM_AW:0]   ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic              ready_q;

    logic [7:0]        ram [RamDepth];

    logic              accept;
    logic              addr_in_ram;
    logic              addr_is_vec;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    // Handshake and address decode.
    always_comb begin
        load_ready  = ready_q & resetn;
        accept      = load_valid & load_ready;
        addr_in_ram = (32'(address) < RamDepth);
        addr_is_vec = (address == 16'hFFFC) || (address == 16'hFFFD);
    end

    // Single RAM write port shared by the loader and the processor.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ptr_q[RAM_AW-1:0];
        ram_wdata = load_data;
        if (accept && (state_q == StLoad) && !ptr_q[RAM_AW]) begin
            ram_we = 1'b1;
        end
`ifdef MEM_WRITE_EN
        if ((state_q == StRun) && we && addr_in_ram && !addr_is_vec) begin
            ram_we    = 1'b1;
            ram_waddr = address[RAM_AW-1:0];
            ram_wdata = wr_data;
        end
`endif
    end

    // Load sequencing FSM with registered ready, processor reset and overflow flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StVecLo;
            vec_lo_q    <= 8'h00;
            vec_hi_q    <= 8'h00;
            ptr_q       <= PtrBase;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            load_ovf    <= 1'b0;
            proc_resetn <= 1'b0;
        end else begin
            unique case (state_q)
                StVecLo: begin
                    if (accept) begin
                        vec_lo_q <= load_data;
                        if (load_last) begin
                            state_q <= StRelease;
                            ready_q <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StVecHi;
                        end
                    end
                end
                StVecHi: begin
                    if (accept) begin
                        vec_hi_q <= load_data;
                        if (load_last) begin
                            state_q <= StRelease;
                            ready_q <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StLoad;
                            ptr_q   <= PtrBase;
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        // Full RAM: drop the byte but still complete the handshake.
                        if (ptr_q[RAM_AW]) begin
                            load_ovf <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                        if (load_last) begin
                            state_q <= StRelease;
                            ready_q <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end
                end
                StRelease: begin
                    if (cnt_q == RelLast) begin
                        state_q     <= StRun;
                        proc_resetn <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                end
                default: begin
                    state_q <= StVecLo;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // RAM array, deliberately not reset so contents survive a reload.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Registered read mux; a same-cycle write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data <= 8'hFF;
        end else if (address == 16'hFFFC) begin
            rd_data <= vec_lo_q;
        end else if (address == 16'hFFFD) begin
            rd_data <= vec_hi_q;
        end else if (addr_in_ram) begin
            rd_data <= ram[address[RAM_AW-1:0]];
        end else begin
            rd_data <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: a default instance (4 KiB RAM) and a small one
// (RAM_AW=4) share one stimulus stream and are checked against a model that
// maps stream position to vector/RAM location.
module tb_mem_loader;

    logic        clk;
    logic        resetn;
    logic [15:0] address;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
`ifdef MEM_WRITE_EN
    logic        we;
    logic [7:0]  wr_data;
`endif

    logic [7:0]  rd_data,   s_rd_data;
    logic        load_ready, s_load_ready;
    logic        proc_resetn, s_proc_resetn;
    logic        load_ovf,  s_load_ovf;

    mem_loader dut (
`ifdef MEM_WRITE_EN
        .we          (we),
        .wr_data     (wr_data),
`endif
        .clk         (clk),
        .resetn      (resetn),
        .address     (address),
        .rd_data     (rd_data),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .proc_resetn (proc_resetn),
        .load_ovf    (load_ovf)
    );

    mem_loader #(.RAM_AW(4)) dut_s (
`ifdef MEM_WRITE_EN
        .we          (we),
        .wr_data     (wr_data),
`endif
        .clk         (clk),
        .resetn      (resetn),
        .address     (address),
        .rd_data     (s_rd_data),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (s_load_ready),
        .proc_resetn (s_proc_resetn),
        .load_ovf    (s_load_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt  = 0;

    // Count handshakes on the default instance.
    always @(posedge clk) begin
        if (load_valid && load_ready) acc_cnt <= acc_cnt + 1;
    end

    // Reference model: vectors, RAM image and program byte count of the last stream.
    logic [7:0] m_ram [0:4095];
    logic [7:0] m_vlo;
    logic [7:0] m_vhi;
    int         n_prog;
    logic [7:0] stream [$];

    function automatic logic [7:0] exp_rd(input logic [15:0] a, input int unsigned depth);
        if (a == 16'hFFFC) return m_vlo;
        if (a == 16'hFFFD) return m_vhi;
        if (32'(a) < depth) return m_ram[a[11:0]];
        return 8'hFF;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk1("rst_ready",   load_ready,    1'b0);
        chk1("rst_ready_s", s_load_ready,  1'b0);
        chk1("rst_proc",    proc_resetn,   1'b0);
        chk1("rst_proc_s",  s_proc_resetn, 1'b0);
        chk1("rst_ovf",     load_ovf,      1'b0);
        chk1("rst_ovf_s",   s_load_ovf,    1'b0);
        chk("rst_rd",       rd_data,       8'hFF);
        chk("rst_rd_s",     s_rd_data,     8'hFF);
        resetn = 1'b1;
        m_vlo  = 8'h00;
        m_vhi  = 8'h00;
        #1;
    endtask

    task automatic read2(input logic [15:0] a);
        address = a;
        @(posedge clk);
        #1;
        chk($sformatf("rd_%h", a),   rd_data,   exp_rd(a, 4096));
        chk($sformatf("rd_s_%h", a), s_rd_data, exp_rd(a, 16));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int waited;
        waited     = 0;
        load_valid = 1'b1;
        load_data  = b;
        load_last  = last;
        while (!load_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!load_ready) chk1("ready_wait", load_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Stream position 0/1 are vectors, position i>=2 is RAM[i-2] (LOAD_BASE = 0).
    task automatic run_stream(input bit with_last, input bit hold);
        logic lst;
        n_prog = 0;
        for (int i = 0; i < stream.size(); i++) begin
            lst = with_last && (i == stream.size() - 1);
            send_byte(stream[i], lst);
            if (i == 0) m_vlo = stream[i];
            else if (i == 1) m_vhi = stream[i];
            else begin
                n_prog++;
                if (i - 2 < 4096) m_ram[i-2] = stream[i];
            end
        end
        if (hold) begin
            load_data = 8'hEE;
        end else begin
            load_valid = 1'b0;
            load_last  = 1'b0;
        end
        if (with_last) begin
            chk1("rel0_proc",   proc_resetn,   1'b0);
            chk1("rel0_proc_s", s_proc_resetn, 1'b0);
            chk1("rel0_ready",  load_ready,    1'b0);
            @(posedge clk);
            #1;
            chk1("rel1_proc",   proc_resetn,   1'b0);
            chk1("rel1_proc_s", s_proc_resetn, 1'b0);
            @(posedge clk);
            #1;
            chk1("run_proc",    proc_resetn,   1'b1);
            chk1("run_proc_s",  s_proc_resetn, 1'b1);
            chk1("run_ready",   load_ready,    1'b0);
            chk1("ovf",         load_ovf,      n_prog > 4096);
            chk1("ovf_s",       s_load_ovf,    n_prog > 16);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1);
    end

    initial begin
        int a0;
        logic [15:0] ra;
        resetn     = 1'b0;
        address    = 16'hFFFC;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
`ifdef MEM_WRITE_EN
        we         = 1'b0;
        wr_data    = 8'h00;
`endif

        // Reset state and cleared vectors.
        do_reset(3);
        chk1("idle_ready", load_ready, 1'b1);
        chk1("idle_proc",  proc_resetn, 1'b0);
        read2(16'hFFFC);
        read2(16'hFFFD);

        // Basic boot stream.
        stream = '{8'hFC, 8'hE0, 8'hEA, 8'h4C, 8'h00, 8'h00};
        run_stream(1'b1, 1'b0);
        read2(16'hFFFC);
        read2(16'hFFFD);
        for (int i = 0; i < 4; i++) read2(16'(i));

        // Loader inputs ignored once running.
        a0 = acc_cnt;
        load_valid = 1'b1;
        load_data  = 8'h99;
        load_last  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("run_ignore_acc", 8'(acc_cnt - a0), 8'd0);
        read2(16'hFFFC);
        chk1("run_stays", proc_resetn, 1'b1);

        // Valid held high through reset, the load and afterwards: exactly 3 accepts.
        load_valid = 1'b1;
        load_data  = 8'h34;
        load_last  = 1'b0;
        a0 = acc_cnt;
        do_reset(3);
        stream = '{8'h34, 8'h12, 8'hA9};
        run_stream(1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("held_acc", 8'(acc_cnt - a0), 8'd3);
        read2(16'hFFFC);
        read2(16'hFFFD);
        read2(16'h0000);
        read2(16'h0001);

        // 17 program bytes: small instance overflows on the last one.
        do_reset(2);
        stream = {};
        stream.push_back(8'($urandom));
        stream.push_back(8'($urandom));
        for (int i = 1; i <= 17; i++) stream.push_back(8'(i));
        run_stream(1'b1, 1'b0);
        read2(16'h000F);
        read2(16'h0010);
        read2(16'h000E);
        read2(16'h0000);

        // Reset mid-load, then a vector-only reload.
        do_reset(2);
        stream = {};
        for (int i = 0; i < 5; i++) stream.push_back(8'($urandom));
        run_stream(1'b0, 1'b0);
        do_reset(2);
        stream = '{8'h00, 8'h02};
        run_stream(1'b1, 1'b0);
        read2(16'hFFFC);
        read2(16'hFFFD);
        for (int i = 0; i < 5; i++) read2(16'(i));

        // Full random load one byte past the top of the default RAM.
        do_reset(2);
        stream = {};
        for (int i = 0; i < 4099; i++) stream.push_back(8'($urandom));
        stream[2 + 12'hFFF] = 8'h5C;
        run_stream(1'b1, 1'b0);
        read2(16'h0FFF);
        address = 16'h8000;
        #1;
        chk("rd_latency_hold", rd_data, 8'h5C);
        @(posedge clk);
        #1;
        chk("rd_latency_8000", rd_data, 8'hFF);
        read2(16'h1000);
        read2(16'h0000);
        read2(16'hFFFE);
        for (int i = 0; i < 24; i++) begin
            ra = (i % 2 == 0) ? 16'($urandom_range(0, 16'h0FFF)) : 16'($urandom);
            read2(ra);
        end

`ifdef MEM_WRITE_EN
        // Processor write: same-cycle read returns old data; vector writes ignored.
        address = 16'h0010;
        we      = 1'b1;
        wr_data = 8'h5A;
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("wr_old",   rd_data,   exp_rd(16'h0010, 4096));
        chk("wr_old_s", s_rd_data, exp_rd(16'h0010, 16));
        m_ram[12'h010] = 8'h5A;
        read2(16'h0010);
        address = 16'hFFFC;
        we      = 1'b1;
        wr_data = 8'h77;
        @(posedge clk);
        #1;
        we = 1'b0;
        read2(16'hFFFC);
        read2(16'hFFFC);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
